uart_tx_mmio: RTL

- Memory-mapped UART transmitter responder on the CPU data bus, at the MEM stage beside dataMem.
- The pipeline issues stores and loads to it; the block is the responding end of that store path.
- Buffers store bytes in a small FIFO and serialises them 8N1 on the tx line.
- Reports FIFO and shifter state through a readable status word.

---
 rtl/uart_tx_mmio_pkg.sv | 28 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 44 ++++
 rtl/uart_tx_mmio.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: shared addresses, status bit indices and serialiser state encodings.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_mmio_pkg;

   localparam int TX_DATA_ADDR_DEF = 'h3F0;
   localparam int STATUS_ADDR_DEF  = 'h3F1;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_ACTIVE  = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } txState_t;

   function automatic logic evenParity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read data; full pushes are dropped.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr, rdPtr;
   logic             doPush, doPop;

   // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign full   = count == CW'(DEPTH);
   assign empty  = count == '0;
   assign dout   = mem[rdPtr];

   always_ff @(posedge clk)
      if (doPush) mem[wrPtr] <= din;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop) rdPtr <= rdPtr + 1'b1;
         count <= count + CW'(doPush) - CW'(doPop);
      end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with FIFO and status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int                ADDR_W       = 10,
   parameter logic [ADDR_W-1:0] TX_DATA_ADDR = ADDR_W'(TX_DATA_ADDR_DEF),
   parameter logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(STATUS_ADDR_DEF),
   parameter int                DEPTH        = 8,
   parameter int                CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              memWrite,
   input  logic              memRead,
   input  logic [7:0]        writeData,
   output logic [31:0]       readData,
   output logic              tx,
   output logic              txBusy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   txState_t      state, stateNext;
   logic [BW-1:0] baudCnt, baudNext;
   logic [2:0]    bitCnt, bitNext;
   logic [7:0]    shiftReg, shiftNext, fifoDout;
   logic [CW-1:0] fifoCount;
   logic [31:0]   statusWord;
   logic          txNext, popReq, pushReq, statusRd, fifoFull, fifoEmpty, overflow, bitDone;
`ifdef UART_TX_PARITY_EN
   logic          parityBit, parityNext;
`endif

   assign pushReq  = memWrite && address == TX_DATA_ADDR;
   assign statusRd = memRead && address == STATUS_ADDR;
   assign bitDone  = baudCnt == BAUD_LAST;
   assign txBusy   = state != IDLE || !fifoEmpty;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) fifo (
      .clk  (clk),
      .rst  (rst),
      .push (pushReq),
      .pop  (popReq),
      .din  (writeData),
      .dout (fifoDout),
      .full (fifoFull),
      .empty(fifoEmpty),
      .count(fifoCount)
   );

   always_comb begin
      statusWord = '0;
      statusWord[STAT_FULL] = fifoFull;
      statusWord[STAT_EMPTY] = fifoEmpty;
      statusWord[STAT_ACTIVE] = state != IDLE;
      statusWord[STAT_OVF] = overflow;
      statusWord[STAT_CNT_LSB +: 4] = 4'(fifoCount);
   end

   // tx is registered from txNext so the line changes on the same edge as the state.
   always_comb begin
      stateNext = state;
      baudNext = baudCnt;
      bitNext = bitCnt;
      shiftNext = shiftReg;
      txNext = tx;
      popReq = 1'b0;
`ifdef UART_TX_PARITY_EN
      parityNext = parityBit;
`endif
      case (state)
         IDLE:
            if (!fifoEmpty) begin
               popReq = 1'b1;
               shiftNext = fifoDout;
               txNext = 1'b0;
               stateNext = START;
`ifdef UART_TX_PARITY_EN
               parityNext = evenParity(fifoDout);
`endif
            end
         START:
            if (bitDone) begin
               stateNext = DATA;
               txNext = shiftReg[0];
            end
         DATA:
            if (bitDone) begin
               bitNext = bitCnt + 1'b1;
               shiftNext = shiftReg >> 1;
               txNext = shiftReg[1];
               if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  stateNext = PARITY;
                  txNext = parityBit;
`else
                  stateNext = STOP;
                  txNext = 1'b1;
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
         PARITY:
            if (bitDone) begin
               stateNext = STOP;
               txNext = 1'b1;
            end
`endif
         STOP:
            if (bitDone) stateNext = IDLE;
         default: begin
            stateNext = IDLE;
            txNext = 1'b1;
         end
      endcase
      if (state != IDLE) baudNext = bitDone ? '0 : baudCnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         baudCnt <= '0;
         bitCnt <= '0;
         shiftReg <= '0;
         tx <= 1'b1;
         overflow <= 1'b0;
         readData <= '0;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         baudCnt <= baudNext;
         bitCnt <= bitNext;
         shiftReg <= shiftNext;
         tx <= txNext;
         overflow <= (pushReq && fifoFull) || (overflow && !statusRd);
         if (statusRd) readData <= statusWord;
`ifdef UART_TX_PARITY_EN
         parityBit <= parityNext;
`endif
      end

endmodule
